// File: rtl/uwire_if.sv
// uwire_if: host-side write queue, status and readback plus the uWire pin bundle.
interface uwire_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [CountW-1:0]     fifo_count;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  uwire_data;
    logic                  uwire_clk;
    logic                  uwire_le;
    logic                  uwire_miso;

    // Seen from the serial master.
    modport master (
        input  wr_valid, wr_data, uwire_miso,
        output wr_ready, fifo_count, busy, done, rd_data, rd_valid,
               uwire_data, uwire_clk, uwire_le
    );

    // Seen from the sequencer and the device pins.
    modport slave (
        output wr_valid, wr_data, uwire_miso,
        input  wr_ready, fifo_count, busy, done, rd_data, rd_valid,
               uwire_data, uwire_clk, uwire_le
    );
endinterface

// File: rtl/uwire_master.sv
// uwire_master: queued MICROWIRE serial master with readback capture from the device data-out.
module uwire_master #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned HALF_PERIOD = 3,
    parameter int unsigned LE_CYCLES   = 3,
    parameter int unsigned GAP_CYCLES  = 3,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    uwire_if.master bus
);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned BitW   = $clog2(DATA_WIDTH);
    localparam int unsigned MaxLg  = (LE_CYCLES > GAP_CYCLES) ? LE_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxCyc = (HALF_PERIOD > MaxLg) ? HALF_PERIOD : MaxLg;
    localparam int unsigned PhaseW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [PhaseW-1:0] HalfLoad = PhaseW'(HALF_PERIOD - 1);
    localparam logic [PhaseW-1:0] LeLoad   = PhaseW'(LE_CYCLES - 1);
    localparam logic [PhaseW-1:0] GapLoad  = PhaseW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StShiftLo, StShiftHi, StLeSetup, StLeHigh, StGap
    } state_e;

    state_e                state_q, state_d;
    logic [PhaseW-1:0]     phase_q, phase_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] rd_shift_q, rd_shift_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  done_q, done_d;
    logic                  sdata_q, sdata_d;
    logic                  sclk_q, sclk_d;
    logic                  le_q, le_d;
    logic                  miso_s1_q, miso_s2_q;
    logic                  ready_en_q;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic full, empty, push, pop;

    // Ready is derived from registered occupancy only, so a same-cycle pop never frees a slot.
    assign full  = (count_q == CountW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.wr_valid & bus.wr_ready;
    assign pop   = (state_q == StLoad);

    assign bus.wr_ready   = ready_en_q & ~full;
    assign bus.fifo_count = count_q;
    assign bus.busy       = (state_q != StIdle) | ~empty;
    assign bus.done       = done_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.uwire_data = sdata_q;
    assign bus.uwire_clk  = sclk_q;
    assign bus.uwire_le   = le_q;

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase
    end

    // Word sequencer: each timed state counts phase_q down to zero, then moves on.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rd_shift_d = rd_shift_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) state_d = StLoad;
            end
            StLoad: begin
                sh_d    = mem[rd_ptr_q];
                bit_d   = BitW'(DATA_WIDTH - 1);
                phase_d = HalfLoad;
                state_d = StShiftLo;
            end
            StShiftLo: begin
                if (phase_q == '0) begin
                    phase_d = HalfLoad;
                    state_d = StShiftHi;
                end else begin
                    phase_d = phase_q - PhaseW'(1);
                end
            end
            StShiftHi: begin
                if (phase_q == '0) begin
                    // Sample readback late in the high phase to give the device settle time.
                    rd_shift_d = {rd_shift_q[DATA_WIDTH-2:0], miso_s2_q};
                    phase_d    = HalfLoad;
                    if (bit_q == '0) begin
                        state_d = StLeSetup;
                    end else begin
                        bit_d   = bit_q - BitW'(1);
                        sh_d    = {sh_q[DATA_WIDTH-2:0], 1'b0};
                        state_d = StShiftLo;
                    end
                end else begin
                    phase_d = phase_q - PhaseW'(1);
                end
            end
            StLeSetup: begin
                if (phase_q == '0) begin
                    phase_d = LeLoad;
                    state_d = StLeHigh;
                end else begin
                    phase_d = phase_q - PhaseW'(1);
                end
            end
            StLeHigh: begin
                if (phase_q == '0) begin
                    phase_d = GapLoad;
                    state_d = StGap;
                end else begin
                    phase_d = phase_q - PhaseW'(1);
                end
            end
            StGap: begin
                if (phase_q == '0) begin
                    state_d = empty ? StIdle : StLoad;
                end else begin
                    phase_d = phase_q - PhaseW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin and status outputs are registered from the next state so they never glitch.
    always_comb begin
        sclk_d     = (state_d == StShiftHi);
        le_d       = (state_d == StLeHigh);
        sdata_d    = ((state_d == StShiftLo) || (state_d == StShiftHi)) ? sh_d[DATA_WIDTH-1]
                                                                        : 1'b0;
        rd_valid_d = (state_q == StLeSetup) && (state_d == StLeHigh);
        rd_data_d  = rd_valid_d ? rd_shift_q : rd_data_q;
        done_d     = (state_q == StGap) && (state_d == StIdle);
    end

    // State registers with synchronous active-low reset; a reset mid-word drops the word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            rd_shift_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            sdata_q    <= 1'b0;
            sclk_q     <= 1'b0;
            le_q       <= 1'b0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
            ready_en_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            rd_shift_q <= rd_shift_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            sdata_q    <= sdata_d;
            sclk_q     <= sclk_d;
            le_q       <= le_d;
            miso_s1_q  <= bus.uwire_miso;
            miso_s2_q  <= miso_s1_q;
            ready_en_q <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.wr_data;
    end
endmodule

// File: tb/tb_uwire_master.sv
// tb_uwire_master: directed vectors and corner sequences for the uWire master.
module tb_uwire_master;
    logic clk;
    logic rst_n;

    uwire_if #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) b0 ();
    uwire_if #(.DATA_WIDTH(24), .FIFO_DEPTH(4))  b1 ();

    uwire_master #(
        .DATA_WIDTH(32), .HALF_PERIOD(3), .LE_CYCLES(3), .GAP_CYCLES(3), .FIFO_DEPTH(16)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    uwire_master #(
        .DATA_WIDTH(24), .HALF_PERIOD(1), .LE_CYCLES(1), .GAP_CYCLES(1), .FIFO_DEPTH(4)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          rises;
        int          first_rise;
        int          le_rise;
        int          le_fall;
        int          le_len;
        bit          rv_ok;
        logic [31:0] rd;
    } rec_t;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] miso;
        logic [31:0] exp_wire;
        logic [31:0] exp_rd;
    } vec_t;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          push_t   = 0;
    int          cur_rises = 0;
    int          le_rises = 0;
    int          viol_overlap = 0;
    int          viol_data = 0;
    logic [31:0] miso_pat = 32'h0;
    rec_t        recs[$];
    int          done_t[$];
    bit          done_busy[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Holds wr_valid and offers base + step*i until n words are accepted.
    task automatic push_burst(input int n, input logic [31:0] base, input logic [31:0] step,
                              output int max_cnt, output int rdy_errs);
        int i;
        int guard;
        i = 0; guard = 0; max_cnt = 0; rdy_errs = 0;
        @(negedge clk);
        b0.wr_valid = 1'b1;
        while (i < n && guard < 10000) begin
            b0.wr_data = base + step * 32'(i);
            if (int'(b0.fifo_count) > max_cnt) max_cnt = int'(b0.fifo_count);
            if (b0.wr_ready == (b0.fifo_count == 5'd16)) rdy_errs++;
            if (b0.wr_ready) i++;
            @(negedge clk);
            guard++;
        end
        b0.wr_valid = 1'b0;
        check("burst_accepted", 64'(i), 64'(n));
    endtask

    task automatic wait_done(input int n0, input int budget);
        int g;
        g = 0;
        while (done_t.size() <= n0 && g < budget) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", 64'(done_t.size() > n0), 64'(1));
    endtask

    // Wire monitor for the 32-bit instance; a record is closed at each LE fall.
    initial begin
        rec_t cur;
        bit   pclk, ple, pdata;
        int   pcnt;
        cur = '{default: 0};
        pclk = 0; ple = 0; pdata = 0; pcnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                cur = '{default: 0};
            end else begin
                if (b0.uwire_clk && b0.uwire_le) viol_overlap++;
                if (pclk && b0.uwire_clk && (b0.uwire_data !== pdata)) viol_data++;
                if (b0.uwire_clk && !pclk) begin
                    if (cur.rises == 0) cur.first_rise = cyc;
                    cur.word = {cur.word[30:0], b0.uwire_data};
                    cur.rises++;
                end
                if (b0.uwire_le && !ple) begin
                    cur.le_rise = cyc;
                    le_rises++;
                end
                if (b0.uwire_le) cur.le_len++;
                if (b0.rd_valid) begin
                    cur.rd    = b0.rd_data;
                    cur.rv_ok = b0.uwire_le && !ple;
                end
                if (!b0.uwire_le && ple) begin
                    cur.le_fall = cyc;
                    recs.push_back(cur);
                    cur = '{default: 0};
                end
                if (b0.done) begin
                    done_t.push_back(cyc);
                    done_busy.push_back(b0.busy);
                end
                if (pcnt == 0 && b0.fifo_count != 0) push_t = cyc;
            end
            pclk = b0.uwire_clk; ple = b0.uwire_le; pdata = b0.uwire_data;
            pcnt = int'(b0.fifo_count);
            cur_rises = cur.rises;
        end
    end

    // Device readback model: next bit presented after every uWire CLK fall.
    initial begin
        int idx;
        bit pc;
        idx = 0; pc = 0;
        b0.uwire_miso = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || b0.uwire_le) idx = 0;
            else if (pc && !b0.uwire_clk) idx++;
            pc = b0.uwire_clk;
            b0.uwire_miso = (idx < 32) ? miso_pat[31 - idx] : 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vec [4];
        rec_t        r;
        int          mc, re, n0, nd, g, le0, errs;
        int          v_rises, v_le_len, v_done, v_ovl;
        int          v_le_t[$];
        logic [23:0] v_word;
        logic [23:0] v_caps[$];
        bit          v_pclk, v_ple;

        vec[0] = '{32'h0002_0140, 32'hA5A5_0F0F, 32'h0002_0140, 32'hA5A5_0F0F};
        vec[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vec[2] = '{32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF};
        vec[3] = '{32'h5A5A_C3C3, 32'h1234_5678, 32'h5A5A_C3C3, 32'h1234_5678};

        rst_n = 1'b0;
        b0.wr_valid = 1'b0; b0.wr_data = '0;
        b1.wr_valid = 1'b0; b1.wr_data = '0; b1.uwire_miso = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_uwire_data", 64'(b0.uwire_data), 64'(0));
        check("rst_uwire_clk", 64'(b0.uwire_clk), 64'(0));
        check("rst_uwire_le", 64'(b0.uwire_le), 64'(0));
        check("rst_busy", 64'(b0.busy), 64'(0));
        check("rst_done", 64'(b0.done), 64'(0));
        check("rst_rd_valid", 64'(b0.rd_valid), 64'(0));
        check("rst_rd_data", 64'(b0.rd_data), 64'(0));
        check("rst_fifo_count", 64'(b0.fifo_count), 64'(0));
        check("rst_wr_ready", 64'(b0.wr_ready), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(b0.wr_ready), 64'(1));

        // Single words from idle: wire content, bit timing, LE, readback and done.
        for (int i = 0; i < 4; i++) begin
            miso_pat = vec[i].miso;
            n0 = recs.size();
            nd = done_t.size();
            push_burst(1, vec[i].wdata, 32'h0, mc, re);
            wait_done(nd, 400);
            check("vec_records", 64'(recs.size()), 64'(n0 + 1));
            r = recs[n0];
            check("vec_wire_word", 64'(r.word), 64'(vec[i].exp_wire));
            check("vec_rises", 64'(r.rises), 64'(32));
            check("vec_first_rise", 64'(r.first_rise - push_t), 64'(5));
            check("vec_le_offset", 64'(r.le_rise - r.first_rise), 64'(192));
            check("vec_le_len", 64'(r.le_len), 64'(3));
            check("vec_rd_at_le", 64'(r.rv_ok), 64'(1));
            check("vec_rd_data", 64'(r.rd), 64'(vec[i].exp_rd));
            check("vec_done_offset", 64'(done_t[nd] - r.first_rise), 64'(198));
            check("vec_busy_at_done", 64'(done_busy[nd]), 64'(0));
        end

        // Three queued words: 202-cycle LE spacing, 3-cycle gap, a single done.
        n0 = recs.size();
        nd = done_t.size();
        push_burst(3, 32'h11, 32'h11, mc, re);
        wait_done(nd, 1000);
        repeat (20) @(negedge clk);
        check("b3_records", 64'(recs.size()), 64'(n0 + 3));
        check("b3_word0", 64'(recs[n0].word), 64'(32'h11));
        check("b3_word1", 64'(recs[n0 + 1].word), 64'(32'h22));
        check("b3_word2", 64'(recs[n0 + 2].word), 64'(32'h33));
        check("b3_le_space01", 64'(recs[n0 + 1].le_rise - recs[n0].le_rise), 64'(202));
        check("b3_le_space12", 64'(recs[n0 + 2].le_rise - recs[n0 + 1].le_rise), 64'(202));
        check("b3_gap01", 64'(recs[n0 + 1].first_rise - recs[n0].le_fall), 64'(7));
        check("b3_gap12", 64'(recs[n0 + 2].first_rise - recs[n0 + 1].le_fall), 64'(7));
        check("b3_done_once", 64'(done_t.size()), 64'(nd + 1));
        check("b3_done_offset", 64'(done_t[nd] - recs[n0 + 2].first_rise), 64'(198));

        // Twenty words into a 16-deep FIFO with wr_valid held.
        n0 = recs.size();
        nd = done_t.size();
        push_burst(20, 32'hC0DE_0000, 32'h1, mc, re);
        check("b20_max_count", 64'(mc), 64'(16));
        check("b20_ready_errs", 64'(re), 64'(0));
        wait_done(nd, 6000);
        check("b20_records", 64'(recs.size()), 64'(n0 + 20));
        errs = 0;
        for (int j = 0; j < 20; j++) begin
            if (recs[n0 + j].word !== (32'hC0DE_0000 + 32'(j))) errs++;
        end
        check("b20_order_errs", 64'(errs), 64'(0));

        // Reset at bit 10 with three words still queued.
        push_burst(4, 32'hDEAD_0001, 32'h1, mc, re);
        g = 0;
        while (cur_rises < 11 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid_reached", 64'(cur_rises), 64'(11));
        check("rst_mid_queued", 64'(b0.fifo_count), 64'(3));
        le0 = le_rises;
        n0  = recs.size();
        nd  = done_t.size();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_data", 64'(b0.uwire_data), 64'(0));
        check("rst_mid_clk", 64'(b0.uwire_clk), 64'(0));
        check("rst_mid_le", 64'(b0.uwire_le), 64'(0));
        check("rst_mid_count", 64'(b0.fifo_count), 64'(0));
        check("rst_mid_busy", 64'(b0.busy), 64'(0));
        @(negedge clk);
        check("rst_mid_ready", 64'(b0.wr_ready), 64'(1));
        repeat (300) @(negedge clk);
        check("rst_mid_no_le", 64'(le_rises), 64'(le0));
        check("rst_mid_no_done", 64'(done_t.size()), 64'(nd));
        push_burst(1, 32'h0BAD_F00D, 32'h0, mc, re);
        wait_done(nd, 400);
        check("rst_mid_after_rec", 64'(recs.size()), 64'(n0 + 1));
        check("rst_mid_after_word", 64'(recs[n0].word), 64'(32'h0BAD_F00D));

        // 24-bit, minimum-timing instance: two words.
        v_rises = 0; v_le_len = 0; v_done = 0; v_ovl = 0; v_word = '0;
        v_pclk = 0; v_ple = 0;
        @(negedge clk);
        b1.wr_valid = 1'b1;
        b1.wr_data  = 24'hABCDEF;
        @(posedge clk);
        #1 b1.wr_data = 24'h123456;
        @(posedge clk);
        #1 b1.wr_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (b1.uwire_clk && !v_pclk) begin
                v_rises++;
                v_word = {v_word[22:0], b1.uwire_data};
            end
            if (b1.uwire_le && !v_ple) begin
                v_le_t.push_back(c);
                v_caps.push_back(v_word);
            end
            if (b1.uwire_le) v_le_len++;
            if (b1.uwire_le && b1.uwire_clk) v_ovl++;
            if (b1.done) v_done++;
            v_pclk = b1.uwire_clk;
            v_ple  = b1.uwire_le;
        end
        check("w24_rises", 64'(v_rises), 64'(48));
        check("w24_le_pulses", 64'(v_le_t.size()), 64'(2));
        check("w24_period", 64'(v_le_t[1] - v_le_t[0]), 64'(52));
        check("w24_le_cycles", 64'(v_le_len), 64'(2));
        check("w24_word0", 64'(v_caps[0]), 64'(24'hABCDEF));
        check("w24_word1", 64'(v_caps[1]), 64'(24'h123456));
        check("w24_done", 64'(v_done), 64'(1));
        check("w24_clk_le_overlap", 64'(v_ovl), 64'(0));

        check("clk_le_overlap", 64'(viol_overlap), 64'(0));
        check("data_change_clk_high", 64'(viol_data), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
